ilm_ae_pipe: RTL and testbench

Parametrised, 3-stage pipelined improved logarithmic multiplier with approximate error compensation.
- Multiplies two WIDTH-bit operands using nearest-one (power-of-two) decomposition.
- Per-transaction signed/unsigned mode; valid/ready handshake on both sides.
- Sits in the approximate-arithmetic datapath as the streaming successor of the 16-bit combinational ILM.

---
 rtl/ilm_ae_pipe.sv | 137 +++++++++++++
 tb/tb_ilm_ae_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ilm_ae_pipe.sv
// Three-stage pipelined improved logarithmic multiplier (nearest-one decomposition)
// with constant-pattern LSB compensation. Define ILM_EXACT_ABS_EN for exact negation.
module ilm_ae_pipe #(
  parameter int WIDTH = 16,
  parameter int TRUNC = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int PW = 2 * WIDTH;
  localparam int QW = PW + 2;
  localparam int DW = WIDTH + 2;
  localparam int NW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] TMASK = {PW{1'b1}} >> (PW - TRUNC);
  localparam logic [PW-1:0] ALT   = {WIDTH{2'b10}} & TMASK;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
`ifdef ILM_EXACT_ABS_EN
    return s ? (~v + WIDTH'(1)) : v;
`else
    return v ^ {WIDTH{s}};
`endif
  endfunction

  // Rounds floor(log2 a) up when the bit just below the leading one is set.
  function automatic logic [NW-1:0] near_exp(input logic [WIDTH-1:0] a);
    logic [NW-1:0] m;
    logic          up;
    m  = '0;
    up = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (a[i]) begin
        m  = NW'(i);
        up = a[i-1];
      end
    end
    return m + NW'(up);
  endfunction

  function automatic logic signed [DW-1:0] residue(input logic [WIDTH-1:0] a,
                                                   input logic [NW-1:0]    n);
    return $signed({2'b00, a}) - $signed(DW'(1) << n);
  endfunction

  function automatic logic [PW-1:0] saturate(input logic signed [QW-1:0] q);
    logic signed [QW-1:0] lim;
    lim = $signed({2'b00, {PW{1'b1}}});
    return (q > lim) ? {PW{1'b1}} : q[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] ilm_sum(input logic [NW-1:0] nx, input logic [NW-1:0] ny,
                                            input logic signed [DW-1:0] dx,
                                            input logic signed [DW-1:0] dy);
    logic signed [QW-1:0] tx, ty, q;
    logic [NW:0]          e;
    e  = {1'b0, nx} + {1'b0, ny};
    tx = $signed({{(QW-DW){dx[DW-1]}}, dx});
    ty = $signed({{(QW-DW){dy[DW-1]}}, dy});
    q  = $signed(QW'(1) << e) + (tx <<< ny) + (ty <<< nx);
    return saturate(q);
  endfunction

  function automatic logic [PW-1:0] finish(input logic [PW-1:0] q, input logic ps,
                                           input logic zero);
    logic [PW-1:0] qc, r;
    qc = (q & ~TMASK) | ALT;
`ifdef ILM_EXACT_ABS_EN
    r = ps ? (~qc + PW'(1)) : qc;
`else
    r = ps ? ~qc : qc;
`endif
    return zero ? '0 : r;
  endfunction

  logic                    adv;
  logic                    sx, sy;
  logic [WIDTH-1:0]        ax, ay;
  logic                    vld_p0, vld_p1, vld_p2;
  logic [NW-1:0]           nx_p0, ny_p0;
  logic signed [DW-1:0]    dx_p0, dy_p0;
  logic                    ps_p0, zero_p0;
  logic [PW-1:0]           q_p1;
  logic                    ps_p1, zero_p1;
  logic [PW-1:0]           p_p2;

  assign adv       = ~vld_p2 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign out_p     = p_p2;

  assign sx = in_signed & in_x[WIDTH-1];
  assign sy = in_signed & in_y[WIDTH-1];
  assign ax = magnitude(in_x, sx);
  assign ay = magnitude(in_y, sy);

  // Valid bits and the visible product are cleared by reset; internal data is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      p_p2   <= '0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      // stage 3: compensate, apply sign, force zero
      p_p2   <= finish(q_p1, ps_p1, zero_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      // stage 1: magnitude, nearest-one exponent, residue
      nx_p0   <= near_exp(ax);
      ny_p0   <= near_exp(ay);
      dx_p0   <= residue(ax, near_exp(ax));
      dy_p0   <= residue(ay, near_exp(ay));
      ps_p0   <= sx ^ sy;
      zero_p0 <= (ax == '0) | (ay == '0);
      // stage 2: partial-product sum with saturation
      q_p1    <= ilm_sum(nx_p0, ny_p0, dx_p0, dy_p0);
      ps_p1   <= ps_p0;
      zero_p1 <= zero_p0;
    end
  end

endmodule

// File: tb/tb_ilm_ae_pipe.sv
// Bench for ilm_ae_pipe: two instances (TRUNC=12 and TRUNC=0) share stimulus and are
// compared against an arithmetic reference model and a slot-level pipeline model.
module tb_ilm_ae_pipe;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_signed, out_ready;
  logic [W-1:0]  in_x, in_y;
  logic          in_ready, out_valid, in_ready0, out_valid0;
  logic [2*W-1:0] out_p, out_p0;

  always #5 clk = ~clk;

  ilm_ae_pipe #(.WIDTH(W), .TRUNC(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p));

  ilm_ae_pipe #(.WIDTH(W), .TRUNC(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_signed(in_signed),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0));

  int checks = 0;
  int failures = 0;
  bit mv[3];
  logic [31:0] m12[3];
  logic [31:0] m0[3];
  int n_acc = 0;
  int n_dut_out = 0;
  bit obs_valid;
  logic [31:0] obs_p12, obs_p0;
  bit last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint mag_of(input logic [15:0] v, input bit s);
`ifdef ILM_EXACT_ABS_EN
    return s ? 65536 - longint'(v) : longint'(v);
`else
    return s ? 65535 - longint'(v) : longint'(v);
`endif
  endfunction

  // Nearest power-of-two exponent: round up when a >= 1.5 * 2^floor(log2 a).
  function automatic int near(input longint a);
    int m;
    m = 0;
    if (a == 0) return 0;
    while ((longint'(1) << (m + 1)) <= a) m++;
    if (2 * a >= 3 * (longint'(1) << m)) return m + 1;
    return m;
  endfunction

  function automatic logic [31:0] ref_p(input logic [15:0] x, input logic [15:0] y,
                                        input bit sg, input int trunc);
    bit     sx, sy;
    longint ax, ay, q, lim, md;
    int     nx, ny;
    sx  = sg & x[15];
    sy  = sg & y[15];
    ax  = mag_of(x, sx);
    ay  = mag_of(y, sy);
    lim = longint'(1) << 32;
    if (ax == 0 || ay == 0) return 32'h0;
    nx = near(ax);
    ny = near(ay);
    q  = (longint'(1) << (nx + ny)) + (ax - (longint'(1) << nx)) * (longint'(1) << ny)
       + (ay - (longint'(1) << ny)) * (longint'(1) << nx);
    if (q > lim - 1) q = lim - 1;
    if (trunc > 0) begin
      md = longint'(1) << trunc;
      q  = q - (q % md) + (longint'(32'hAAAAAAAA) % md);
    end
    if (sx ^ sy) begin
`ifdef ILM_EXACT_ABS_EN
      q = (lim - q) % lim;
`else
      q = (lim - 1) - q;
`endif
    end
    return q[31:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick(input bit iv, input logic [15:0] x, input logic [15:0] y,
                      input bit sg, input bit ordy);
    bit adv;
    @(negedge clk);
    obs_valid = out_valid;
    obs_p12   = out_p;
    obs_p0    = out_p0;
    check("out_valid", out_valid, mv[2]);
    check("out_valid_t0", out_valid0, mv[2]);
    if (mv[2]) begin
      check("out_p_t12", out_p, m12[2]);
      check("out_p_t0", out_p0, m0[2]);
    end
    in_valid  = iv;
    in_x      = x;
    in_y      = y;
    in_signed = sg;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !mv[2] || ordy);
    check("in_ready_t0", in_ready0, !mv[2] || ordy);
    @(posedge clk);
    adv = !mv[2] || ordy;
    last_acc = adv && iv;
    if (obs_valid && ordy) n_dut_out++;
    if (adv) begin
      mv[2] = mv[1]; m12[2] = m12[1]; m0[2] = m0[1];
      mv[1] = mv[0]; m12[1] = m12[0]; m0[1] = m0[0];
      mv[0] = iv;
      m12[0] = ref_p(x, y, sg, 12);
      m0[0]  = ref_p(x, y, sg, 0);
      if (iv) n_acc++;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input bit sg, input logic [31:0] e12, input logic [31:0] e0);
    int lat;
    lat = 0;
    tick(1'b1, x, y, sg, 1'b1);
    check({tag, "_accept"}, last_acc, 1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      lat++;
      if (obs_valid) break;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_p_t12"}, obs_p12, e12);
    check({tag, "_p_t0"}, obs_p0, e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    logic [15:0] sxv, syv;
    bit ssv;
    in_valid = 1'b0; in_signed = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_p_t0", out_p0, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    directed("u100x200", 16'd100, 16'd200, 1'b0, 32'h00004AAA, 32'h00004800);
    directed("u3x3", 16'd3, 16'd3, 1'b0, 32'h00000AAA, 32'h00000008);
    directed("umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0AAA, 32'hFFFE0000);
`ifdef ILM_EXACT_ABS_EN
    directed("sneg100", 16'hFF9C, 16'd200, 1'b1, 32'hFFFFB556, 32'hFFFFB800);
    directed("sm1", 16'hFFFF, 16'd1234, 1'b1, 32'hFFFFF556, 32'hFFFFFB2E);
`else
    directed("sneg100", 16'hFF9C, 16'd200, 1'b1, 32'hFFFFB555, 32'hFFFFB8FF);
    directed("sm1", 16'hFFFF, 16'd1234, 1'b1, 32'h0, 32'h0);
`endif
    directed("szero", 16'h0000, 16'd1234, 1'b1, 32'h0, 32'h0);

    // mixed-mode burst with a 4-cycle downstream stall
    sent = 0; cyc = 0;
    sxv = pick(); syv = pick(); ssv = 1'b0;
    while (sent < 8 && cyc < 40) begin
      tick(1'b1, sxv, syv, ssv, !(cyc >= 4 && cyc < 8));
      if (last_acc) begin
        sent++;
        sxv = pick(); syv = pick(); ssv = ~ssv;
      end
      cyc++;
    end
    check("stream_sent", sent, 8);
    repeat (4) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    repeat (200)
      tick($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7);
    repeat (5) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("no_loss_dup", n_dut_out, n_acc);

    // reset with three slots in flight
    repeat (3) tick(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_valid_t0", out_valid0, 0);
    check("midrst_out_p", out_p, 0);
    check("midrst_out_p_t0", out_p0, 0);
    for (int i = 0; i < 3; i++) mv[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    directed("post_rst", 16'd100, 16'd200, 1'b0, 32'h00004AAA, 32'h00004800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
